// File: rtl/mm_pkg.sv
// Shared sizes and FSM encoding for the matrix-multiplier result sink.
// Pure declarations; no logic.
package mm_pkg;
    localparam int N          = 16;
    localparam int DATA_WIDTH = 32;
    localparam int IDX_WIDTH  = 5;
    localparam int LIN_W      = 2 * IDX_WIDTH;
    localparam int DEPTH      = N * N;
    localparam int AW         = $clog2(DEPTH);
    localparam int CNT_W      = 16;
    localparam int TICK_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_ACK_HI,
        ST_DONE
    } state_t;
endpackage

// File: rtl/mm_result_sink_ram.sv
// N*N result store: one write port, one registered read port (1-cycle latency).
// Never stalls; out-of-range read addresses return 0, same-address write/read returns old word.
module result_ram
    import mm_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [LIN_W-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [LIN_W-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    // Contents are deliberately left uninitialised across reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_addr < LIN_W'(DEPTH)) begin
            rd_data_d = mem[rd_addr[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/mm_result_sink.sv
// Host-side sink for matrix-multiplier results: four-phase element handshake, result RAM, latency capture.
// Element acked the cycle after elem_rdy; ack held until elem_rdy drops, which is the only backpressure.
module mm_result_sink
    import mm_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  arm,
    input  logic                  elem_rdy,
    input  logic [IDX_WIDTH-1:0]  rrow,
    input  logic [IDX_WIDTH-1:0]  rcol,
    input  logic [DATA_WIDTH-1:0] acc,
    output logic                  ack_elem,
    input  logic                  mm_done,
    input  logic [TICK_W-1:0]     ticks,
    output logic                  ack_ticks,
    input  logic [LIN_W-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0]      count,
    output logic [TICK_W-1:0]     lat,
    output logic                  done,
    output logic                  err_dup,
    output logic                  err_range,
    output logic                  err_miss
);
    state_t             state_q, state_d;
    logic               ack_elem_q, ack_elem_d;
    logic               ack_ticks_q, ack_ticks_d;
    logic               done_q, done_d;
    logic               err_dup_q, err_dup_d;
    logic               err_range_q, err_range_d;
    logic               err_miss_q, err_miss_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TICK_W-1:0]  lat_q, lat_d;
    logic [DEPTH-1:0]   bitmap_q, bitmap_d;
    logic [LIN_W-1:0]   lin_idx;
    logic               in_range;
    logic               ram_we;

    assign in_range = ({1'b0, rrow} < (IDX_WIDTH + 1)'(N)) &&
                      ({1'b0, rcol} < (IDX_WIDTH + 1)'(N));
    assign lin_idx  = LIN_W'(rrow) * LIN_W'(N) + LIN_W'(rcol);

    always_comb begin
        state_d     = state_q;
        ack_elem_d  = ack_elem_q;
        ack_ticks_d = ack_ticks_q;
        done_d      = done_q;
        err_dup_d   = err_dup_q;
        err_range_d = err_range_q;
        err_miss_d  = err_miss_q;
        count_d     = count_q;
        lat_d       = lat_q;
        bitmap_d    = bitmap_q;
        ram_we      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d     = ST_WAIT_RDY;
                    ack_ticks_d = 1'b0;
                    done_d      = 1'b0;
                    err_dup_d   = 1'b0;
                    err_range_d = 1'b0;
                    err_miss_d  = 1'b0;
                    count_d     = '0;
                    bitmap_d    = '0;
                end
            end
            ST_WAIT_RDY: begin
                // An element pending alongside mm_done is serviced first.
                if (elem_rdy) begin
                    ack_elem_d = 1'b1;
                    state_d    = ST_ACK_HI;
                    if (in_range) begin
                        ram_we = 1'b1;
                        if (bitmap_q[lin_idx[AW-1:0]]) begin
                            err_dup_d = 1'b1;
                        end
                        bitmap_d[lin_idx[AW-1:0]] = 1'b1;
                        if (count_q != '1) begin
                            count_d = count_q + 16'd1;
                        end
                    end else begin
                        err_range_d = 1'b1;
                    end
                end else if (mm_done) begin
                    lat_d       = ticks;
                    ack_ticks_d = 1'b1;
                    done_d      = 1'b1;
                    err_miss_d  = (count_q != CNT_W'(DEPTH));
                    state_d     = ST_DONE;
                end
            end
            ST_ACK_HI: begin
                if (!elem_rdy) begin
                    ack_elem_d = 1'b0;
                    state_d    = ST_WAIT_RDY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ack_elem_q  <= 1'b0;
            ack_ticks_q <= 1'b0;
            done_q      <= 1'b0;
            err_dup_q   <= 1'b0;
            err_range_q <= 1'b0;
            err_miss_q  <= 1'b0;
            count_q     <= '0;
            lat_q       <= '0;
            bitmap_q    <= '0;
        end else begin
            state_q     <= state_d;
            ack_elem_q  <= ack_elem_d;
            ack_ticks_q <= ack_ticks_d;
            done_q      <= done_d;
            err_dup_q   <= err_dup_d;
            err_range_q <= err_range_d;
            err_miss_q  <= err_miss_d;
            count_q     <= count_d;
            lat_q       <= lat_d;
            bitmap_q    <= bitmap_d;
        end
    end

    result_ram u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (ram_we & reset_n),
        .wr_addr (lin_idx),
        .wr_data (acc),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign ack_elem  = ack_elem_q;
    assign ack_ticks = ack_ticks_q;
    assign done      = done_q;
    assign err_dup   = err_dup_q;
    assign err_range = err_range_q;
    assign err_miss  = err_miss_q;
    assign count     = count_q;
    assign lat       = lat_q;
endmodule
